// File: rtl/banco_registradores_pkg.sv
// Shared constants for the banco_registradores register file slice.
// Optional build macro: REGFILE_BYPASS_EN (same-edge write forwarding to reads).
package banco_registradores_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** DEF_ADDR_W;
  localparam int REG_ZERO   = 0;

  // True when the index names the hardwired zero register.
  function automatic logic is_reg_zero(input logic [DEF_ADDR_W-1:0] idx);
    return idx == DEF_ADDR_W'(REG_ZERO);
  endfunction

endpackage

// File: rtl/banco_registradores_if.sv
// Decode/writeback/debug bus of the register file. The master drives indices,
// write data and control; the slave (register file) returns operands and debug data.
interface banco_registradores_if
  import banco_registradores_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              RegWrite;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic              LoadAB;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [ADDR_W-1:0] DbgAddr;
  logic [DATA_W-1:0] DbgData;

  modport master (
    output RegWrite, rd, WriteData, rs, rt, LoadAB, DbgAddr,
    input  A, B, DbgData
  );

  modport slave (
    input  RegWrite, rd, WriteData, rs, rt, LoadAB, DbgAddr,
    output A, B, DbgData
  );

endinterface

// File: rtl/banco_registradores_regfile_read_port.sv
// One combinational read port: array index, optional same-edge write
// forwarding (REGFILE_BYPASS_EN), and forcing of register 0 to zero.
module banco_registradores_regfile_read_port
  import banco_registradores_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                  idx,
  input  logic                               wr_en,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic [DATA_W-1:0]                  rd_val
);

  // Select stored value, optionally override with in-flight write, then force r0.
  // NOTE: rd_val gets a default first so no path through this block can infer a latch.
  always_comb begin
    rd_val = regs[idx];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wr_addr == idx)) rd_val = wr_data;
`endif
    if (idx == ADDR_W'(REG_ZERO)) rd_val = '0;
  end

`ifndef REGFILE_BYPASS_EN
  // Write-port signals only matter when forwarding is built in.
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

endmodule

// File: rtl/banco_registradores.sv
// 32-entry register file with registered ALU operands A/B and a debug read port.
// Register 0 reads as zero. Build macro REGFILE_BYPASS_EN enables same-edge
// forwarding of the write port into all three read ports.
module banco_registradores
  import banco_registradores_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DBG_EN = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  banco_registradores_if.slave bus
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [DATA_W-1:0]            a_q;
  logic [DATA_W-1:0]            b_q;
  logic [DATA_W-1:0]            a_val;
  logic [DATA_W-1:0]            b_val;
  logic [DATA_W-1:0]            dbg_val;

  banco_registradores_regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
    .regs    (regs),
    .idx     (bus.rs),
    .wr_en   (bus.RegWrite),
    .wr_addr (bus.rd),
    .wr_data (bus.WriteData),
    .rd_val  (a_val)
  );

  banco_registradores_regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
    .regs    (regs),
    .idx     (bus.rt),
    .wr_en   (bus.RegWrite),
    .wr_addr (bus.rd),
    .wr_data (bus.WriteData),
    .rd_val  (b_val)
  );

  generate
    if (DBG_EN != 0) begin : g_dbg
      banco_registradores_regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_dbg (
        .regs    (regs),
        .idx     (bus.DbgAddr),
        .wr_en   (bus.RegWrite),
        .wr_addr (bus.rd),
        .wr_data (bus.WriteData),
        .rd_val  (dbg_val)
      );
    end else begin : g_no_dbg
      assign dbg_val = '0;
      logic unused_dbg;
      assign unused_dbg = ^bus.DbgAddr;
    end
  endgenerate

  // Storage and operand registers: sync reset, guarded write, LoadAB capture.
  // NOTE: the whole array is cleared on reset so no read can ever return X;
  // entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      regs <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      if (bus.RegWrite && (bus.rd != ADDR_W'(REG_ZERO))) regs[bus.rd] <= bus.WriteData;
      if (bus.LoadAB) begin
        a_q <= a_val;
        b_q <= b_val;
      end
    end
  end

  assign bus.A       = a_q;
  assign bus.B       = b_q;
  assign bus.DbgData = dbg_val;

endmodule
